// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a length-prefixed byte image, writes it to imem as LE words, then releases core reset (optional trailer check: BOOT_CHECKSUM_EN)
module imem_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk_t,
  input  logic              rst_t,
  input  logic [7:0]        rx_data_t,
  input  logic              rx_valid_t,
  output logic              rx_ready_t,
  output logic              imem_we_t,
  output logic [ADDR_W-1:0] imem_addr_t,
  output logic [31:0]       imem_wdata_t,
  output logic              core_rst_t,
  output logic              boot_done_t,
  output logic              boot_err_t,
  output logic [15:0]       words_loaded_t
);
  typedef enum logic [2:0] {
    HDR_LO, HDR_HI, CHECK_LEN, PAYLOAD, WRITE, RUN, ERROR
`ifdef BOOT_CHECKSUM_EN
    , CSUM
`endif
  } state_t;
`ifdef BOOT_CHECKSUM_EN
  localparam state_t DONE_ST = CSUM;
`else
  localparam state_t DONE_ST = RUN;
`endif
  state_t              state_q;
  logic [15:0]         len_q;
  logic [15:0]         idx_q;
  logic [1:0]          lane_q;
  logic [23:0]         buf_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [15:0]         words_q;
  logic                accept;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif
  assign rx_ready_t = !rst_t && (state_q == HDR_LO || state_q == HDR_HI || state_q == PAYLOAD
`ifdef BOOT_CHECKSUM_EN
                                 || state_q == CSUM
`endif
                                 );
  assign accept         = rx_valid_t && rx_ready_t;
  assign imem_we_t      = we_q;
  assign imem_addr_t    = addr_q;
  assign imem_wdata_t   = wdata_q;
  assign core_rst_t     = state_q != RUN;
  assign boot_done_t    = state_q == RUN;
  assign boot_err_t     = state_q == ERROR;
  assign words_loaded_t = words_q;
  // Loader FSM: header capture, length check, byte packing, imem write, terminal RUN/ERROR
  always_ff @(posedge clk_t) begin
    if (rst_t) begin
      state_q <= HDR_LO;
      len_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      buf_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= ADDR_W'(BASE_ADDR);
      wdata_q <= '0;
      words_q <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        HDR_LO: if (accept) begin
          len_q[7:0] <= rx_data_t;
          state_q    <= HDR_HI;
        end
        HDR_HI: if (accept) begin
          len_q[15:8] <= rx_data_t;
          state_q     <= CHECK_LEN;
        end
        CHECK_LEN: begin
          idx_q   <= '0;
          lane_q  <= '0;
          state_q <= (32'(len_q) > MAX_WORDS) ? ERROR : (len_q == 16'd0) ? DONE_ST : PAYLOAD;
        end
        PAYLOAD: if (accept) begin
          buf_q  <= {rx_data_t, buf_q[23:8]};
          lane_q <= lane_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          csum_q <= csum_q ^ rx_data_t;
`endif
          if (lane_q == 2'd3) begin
            we_q    <= 1'b1;
            addr_q  <= ADDR_W'(BASE_ADDR + int'(idx_q));
            wdata_q <= {rx_data_t, buf_q};
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (words_q != 16'hFFFF) words_q <= words_q + 16'd1;
          idx_q   <= idx_q + 16'd1;
          state_q <= (idx_q + 16'd1 == len_q) ? DONE_ST : PAYLOAD;
        end
`ifdef BOOT_CHECKSUM_EN
        CSUM: if (accept) state_q <= (rx_data_t == csum_q) ? RUN : ERROR;
`endif
        default: state_q <= state_q;
      endcase
    end
  end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Boot sequencer for the single-cycle processor.
- After reset it holds the core in reset and receives a program image as a host byte stream over a valid/ready handshake.
- It packs the bytes into little-endian 32-bit words and writes them to instruction memory at consecutive word addresses.
- When the last word is written, it releases the core reset.
- The block sits between the host/test interface and the processor's instruction memory write port and reset input.

Parameters:
- ADDR_W, 10, instruction memory word-address width.
- BASE_ADDR, 0, word address of the first payload word.
- MAX_WORDS, 1024, largest legal image length in words. Rule: BASE_ADDR+MAX_WORDS <= 2^ADDR_W.

Ports:
- clk_t  in  1  system clock; all state changes on the rising edge.
- rst_t  in  1  synchronous, active-high reset.
- rx_data_t  in  8  image byte from the host.
- rx_valid_t  in  1  rx_data_t is valid.
- rx_ready_t  out  1  loader accepts a byte this cycle.
- imem_we_t  out  1  instruction memory write strobe, one cycle per word.
- imem_addr_t  out  ADDR_W  instruction memory word address.
- imem_wdata_t  out  32  instruction memory write data.
- core_rst_t  out  1  processor reset, high until the image is fully loaded.
- boot_done_t  out  1  image loaded, core running.
- boot_err_t  out  1  load aborted.
- words_loaded_t  out  16  count of words written since reset.

Behaviour:
- Handshake: a byte transfers on a rising edge where rx_valid_t && rx_ready_t. The host holds the byte until it is accepted. rx_ready_t is combinational from state, forced 0 while rst_t=1.
- Reset: while rst_t=1 the loader drives rx_ready_t=0, imem_we_t=0, imem_addr_t=BASE_ADDR, imem_wdata_t=0, core_rst_t=1, boot_done_t=0, boot_err_t=0, words_loaded_t=0, and enters HDR_LO. Instruction memory contents are not cleared.
- Image format: length N in words as 2 bytes, low byte first; then 4*N payload bytes, each word least-significant byte first.
- HDR_LO: rx_ready_t=1. On accept, latch N[7:0] and go to HDR_HI.
- HDR_HI: rx_ready_t=1. On accept, latch N[15:8] and go to CHECK_LEN.
- CHECK_LEN: one cycle, rx_ready_t=0. If N > MAX_WORDS, go to ERROR. If N == 0, go to DONE_PATH (defined below). Otherwise go to PAYLOAD with word index 0 and byte lane 0.
- PAYLOAD: rx_ready_t=1.
  - Each accepted byte fills lane 0..3 of the word buffer.
  - When lane 3 is accepted, go to WRITE.
- WRITE: one cycle, rx_ready_t=0.
  - Drive imem_we_t=1, imem_addr_t=(BASE_ADDR+index) mod 2^ADDR_W, imem_wdata_t={b3,b2,b1,b0}.
  - words_loaded_t increments at the end of the cycle.
  - If index+1 == N, go to DONE_PATH; else increment index and go to PAYLOAD.
  - imem_we_t is never high outside WRITE.
- DONE_PATH: RUN, or CSUM when the optional feature is compiled in.
- RUN: core_rst_t=0 and boot_done_t=1 from the first cycle in RUN. rx_ready_t=0, so further host bytes are never accepted. RUN persists until rst_t.
- ERROR: core_rst_t=1, boot_err_t=1, rx_ready_t=0. ERROR persists until rst_t.
- Latency: the first imem_we_t pulse is the cycle after the 4th payload byte is accepted. core_rst_t falls the cycle after the final WRITE (no checksum) or the cycle after the checksum byte is accepted.
- Reset mid-load: an rst_t pulse in any state aborts the load. The loader restarts at HDR_LO and the next image begins at BASE_ADDR.
- Signal stability: imem_addr_t and imem_wdata_t hold their last values when imem_we_t=0. words_loaded_t saturates at 0xFFFF.

Optional Feature:
Macro: BOOT_CHECKSUM_EN.
- With the macro defined:
  - An 8-bit register accumulates the XOR of all payload bytes; it is cleared on reset.
  - DONE_PATH goes to CSUM, where rx_ready_t=1 and one byte is accepted.
  - If the byte equals the accumulator, go to RUN; otherwise go to ERROR.
  - For N == 0 the expected checksum is 0x00.
- Without the macro: CSUM is absent, DONE_PATH goes to RUN, and boot_err_t is raised only by the length check.

Test Plan:
1. Nominal load: stream 02 00 13 05 50 00 93 05 A0 00, rx_valid_t held 1.
   - imem writes: addr 0 = 0x00500513, addr 1 = 0x00A00593.
   - Then core_rst_t=0, boot_done_t=1, words_loaded_t=2.
   - With BOOT_CHECKSUM_EN, append byte 70.
2. Backpressure and gaps: same image with rx_valid_t toggling every other cycle, and a byte presented during WRITE.
   - No byte is lost or duplicated; rx_ready_t=0 during WRITE; identical memory contents.
3. Empty image: stream 00 00.
   - No imem_we_t pulse; RUN reached 2 cycles after the HDR_HI accept (without checksum); words_loaded_t=0.
4. Oversize: N = MAX_WORDS+1 (01 04 for the default).
   - ERROR with boot_err_t=1, core_rst_t stays 1, no writes, rx_ready_t=0 thereafter.
5. Reset mid-payload: assert rst_t for 1 cycle after 6 payload bytes, then send the full nominal image.
   - words_loaded_t=0 after reset; writes restart at addr 0 with correct data.
6. Checksum (BOOT_CHECKSUM_EN): nominal image with trailer 70 reaches RUN; with trailer 71 it goes to ERROR.
   - In the error case: boot_err_t=1, core_rst_t=1, boot_done_t=0.
